// File: rtl/msi_pkg.sv
// msi_pkg: shared definitions for the MSI event arbiter.
//   state_e          - arbiter FSM encoding (IDLE=0, REQ=1, HOLDOFF=2)
//   MSI_MAX_VEC_BITS - widest multi-message field a host can enable (32 vectors)
//   fold_vector()    - maps a source index onto the host-enabled vector range
package msi_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StHoldoff = 2'd2
    } state_e;

    localparam int unsigned MSI_MAX_VEC_BITS = 5;

    // Host may report a wider mmenable than MSI allows; clamp to 5 bits, then
    // keep only the low bits so every source lands on an enabled vector.
    function automatic logic [7:0] fold_vector(input logic [4:0] idx,
                                               input logic [2:0] width);
        logic [2:0] ew;
        logic [4:0] vmask;
        ew    = (width > 3'(MSI_MAX_VEC_BITS)) ? 3'(MSI_MAX_VEC_BITS) : width;
        vmask = 5'((6'd1 << ew) - 6'd1);
        return {3'b000, idx & vmask};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin index finder.
//   req   - request vector, one bit per candidate
//   last  - index granted most recently; search starts at last+1 and wraps
//   valid - at least one request bit is set
//   idx   - first requesting index found after last
module rr_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] req,
    input  logic [4:0]   last,
    output logic         valid,
    output logic [4:0]   idx
);

    logic [31:0] req_ext;
    logic [5:0]  pos;

    assign req_ext = 32'(req);

    always_comb begin
        valid = 1'b0;
        idx   = 5'd0;
        pos   = 6'd0;
        // last < N and k <= N, so one conditional subtract is a full modulo.
        for (int k = 1; k <= int'(N); k++) begin
            pos = 6'(last) + 6'(k);
            if (pos >= 6'(N)) begin
                pos = pos - 6'(N);
            end
            if (!valid && req_ext[pos[4:0]]) begin
                valid = 1'b1;
                idx   = pos[4:0];
            end
        end
    end

endmodule

// File: rtl/msi_event_arbiter.sv
// msi_event_arbiter: latches single-cycle user events as pending bits and issues
// them round-robin as MSI requests on the core's cfg_interrupt/_rdy handshake.
//   clk, rst            - user_clk and synchronous active-high reset
//   event_i             - per-source event pulses
//   src_mask            - 1 blocks selection of a source (pending still latches)
//   msi_enable          - core cfg_interrupt_msienable
//   msi_vector_width    - core cfg_interrupt_mmenable (log2 enabled vectors)
//   cfg_interrupt       - MSI request to the core
//   cfg_interrupt_rdy   - core grant
//   cfg_interrupt_di    - vector number for the request
//   pending             - latched pending bits
//   busy                - FSM is not idle
//   msg_count           - messages granted since reset (wraps)
module msi_event_arbiter
    import msi_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 8,
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   event_i,
    input  logic [NUM_SRC-1:0]   src_mask,
    input  logic                 msi_enable,
    input  logic [2:0]           msi_vector_width,
    output logic                 cfg_interrupt,
    input  logic                 cfg_interrupt_rdy,
    output logic [7:0]           cfg_interrupt_di,
    output logic [NUM_SRC-1:0]   pending,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] msg_count
);

    localparam int unsigned HoldW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [4:0]           last_q, last_d;
    logic [4:0]           sel_q, sel_d;
    logic [7:0]           di_q, di_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [HoldW-1:0]     hold_q, hold_d;

    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   grant_mask;
    logic                 pick_valid;
    logic [4:0]           pick_idx;

    assign eligible = pending_q & ~src_mask;

    rr_pick #(
        .N (NUM_SRC)
    ) u_rr_pick (
        .req   (eligible),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        sel_d      = sel_q;
        di_d       = di_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        grant_mask = '0;

        unique case (state_q)
            StIdle: begin
                if (msi_enable && pick_valid) begin
                    sel_d   = pick_idx;
                    di_d    = fold_vector(pick_idx, msi_vector_width);
                    state_d = StReq;
                end
            end
            // Request is never withdrawn once raised; only rdy moves us on.
            StReq: begin
                if (cfg_interrupt_rdy) begin
                    grant_mask = NUM_SRC'(1) << sel_q;
                    last_d     = sel_q;
                    cnt_d      = cnt_q + CNT_WIDTH'(1);
                    if (HOLDOFF_CYCLES > 0) begin
                        hold_d  = HoldW'(HOLDOFF_CYCLES - 1);
                        state_d = StHoldoff;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHoldoff: begin
                if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear before set: a same-cycle event for the granted source survives.
        pending_d = (pending_q & ~grant_mask) | event_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            last_q    <= 5'(NUM_SRC - 1);
            sel_q     <= 5'd0;
            di_q      <= 8'd0;
            cnt_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            di_q      <= di_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
        end
    end

    assign cfg_interrupt    = (state_q == StReq);
    assign cfg_interrupt_di = di_q;
    assign pending          = pending_q;
    assign busy             = (state_q != StIdle);
    assign msg_count        = cnt_q;

endmodule
